// File: rtl/map_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : map_query_arbiter
// Description : Round-robin arbiter sharing one map-tile lookup port between
//               the player and monster movement FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
module map_query_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int COORD_W  = 10,
    parameter int TYPE_W   = 3,
    parameter int MAP_LAT  = 1,
    parameter int MAP_ROWS = 15,
    parameter int MAP_COLS = 20
) (
    input  logic                       clk_13,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_r,
    input  logic [NUM_REQ*COORD_W-1:0] req_c,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [TYPE_W-1:0]          rsp_type,
    output logic [COORD_W-1:0]         map_r,
    output logic [COORD_W-1:0]         map_c,
    input  logic [TYPE_W-1:0]          map_type
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT_W = $clog2(MAP_LAT + 1);

    localparam logic [COORD_W-1:0] c_map_rows = COORD_W'(MAP_ROWS);
    localparam logic [COORD_W-1:0] c_map_cols = COORD_W'(MAP_COLS);
    localparam logic [TYPE_W-1:0]  c_wall     = TYPE_W'(2);
    localparam logic [LAT_W-1:0]   c_lat_init = LAT_W'(MAP_LAT);
    localparam logic [NUM_REQ-1:0] c_one      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt,    w_gnt_nxt;
    logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
    logic [TYPE_W-1:0]    r_rsp_type,  w_rsp_type_nxt;
    logic [COORD_W-1:0]   r_map_r,  w_map_r_nxt;
    logic [COORD_W-1:0]   r_map_c,  w_map_c_nxt;
    logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]     r_owner,  w_owner_nxt;
    logic [LAT_W-1:0]     r_lat_cnt, w_lat_cnt_nxt;
    logic                 r_oob,    w_oob_nxt;

    logic                 w_found;
    logic [IDX_W-1:0]     w_winner;
    logic [IDX_W-1:0]     w_idx;
    logic [COORD_W-1:0]   w_sel_r;
    logic [COORD_W-1:0]   w_sel_c;

    // Rotating priority scan: first requester at or above rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_sel_r = req_r[w_winner*COORD_W +: COORD_W];
    assign w_sel_c = req_c[w_winner*COORD_W +: COORD_W];

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_type_nxt  = r_rsp_type;
        w_map_r_nxt     = r_map_r;
        w_map_c_nxt     = r_map_c;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_oob_nxt       = r_oob;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_map_r_nxt   = w_sel_r;
                    w_map_c_nxt   = w_sel_c;
                    w_gnt_nxt     = c_one << w_winner;
                    w_owner_nxt   = w_winner;
                    w_rr_ptr_nxt  = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
                    w_lat_cnt_nxt = c_lat_init;
                    w_oob_nxt     = (w_sel_r >= c_map_rows) || (w_sel_c >= c_map_cols);
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_rsp_type_nxt  = r_oob ? c_wall : map_type;
                    w_rsp_valid_nxt = c_one << r_owner;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_13) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_type  <= '0;
            r_map_r     <= '0;
            r_map_c     <= '0;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_lat_cnt   <= '0;
            r_oob       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_type  <= w_rsp_type_nxt;
            r_map_r     <= w_map_r_nxt;
            r_map_c     <= w_map_c_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_oob       <= w_oob_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_type  = r_rsp_type;
    assign map_r     = r_map_r;
    assign map_c     = r_map_c;

endmodule
`default_nettype wire

// File: tb/tb_map_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_query_arbiter
// Description : Directed vector bench for map_query_arbiter (MAP_LAT 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_query_arbiter;

    logic        clk_13 = 1'b0;
    logic        rst;
    logic [3:0]  req_a, req_b;
    logic [39:0] req_r_a, req_c_a, req_r_b, req_c_b;
    logic [3:0]  gnt_a, gnt_b, rsp_valid_a, rsp_valid_b;
    logic [2:0]  rsp_type_a, rsp_type_b, map_type_a, map_type_b;
    logic [9:0]  map_r_a, map_c_a, map_r_b, map_c_b;

    int total = 0;
    int bad   = 0;

    always #5 clk_13 = ~clk_13;

    // Map memory model: tile type derived from the presented address.
    function automatic logic [2:0] tile_of(input logic [9:0] r, input logic [9:0] c);
        logic [31:0] s;
        s = 32'(r) + 32'(c) + 32'd1;
        return s[2:0];
    endfunction

    assign map_type_a = tile_of(map_r_a, map_c_a);
    assign map_type_b = tile_of(map_r_b, map_c_b);

    map_query_arbiter #(.MAP_LAT(1)) u_dut_a (
        .clk_13(clk_13), .rst(rst), .req(req_a), .req_r(req_r_a), .req_c(req_c_a),
        .gnt(gnt_a), .rsp_valid(rsp_valid_a), .rsp_type(rsp_type_a),
        .map_r(map_r_a), .map_c(map_c_a), .map_type(map_type_a)
    );

    map_query_arbiter #(.MAP_LAT(3)) u_dut_b (
        .clk_13(clk_13), .rst(rst), .req(req_b), .req_r(req_r_b), .req_c(req_c_b),
        .gnt(gnt_b), .rsp_valid(rsp_valid_b), .rsp_type(rsp_type_b),
        .map_r(map_r_b), .map_c(map_c_b), .map_type(map_type_b)
    );

    typedef struct {
        logic [3:0]  req;
        logic [39:0] rr;
        logic [39:0] cc;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic [2:0]  typ;
        logic [9:0]  mr;
        logic [9:0]  mc;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_13);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] rq, input logic [39:0] rr, input logic [39:0] cc,
                                input logic [3:0] g, input logic [3:0] rv, input logic [2:0] t,
                                input logic [9:0] mr, input logic [9:0] mc);
        vec_t v;
        v.req = rq; v.rr = rr; v.cc = cc; v.gnt = g; v.rv = rv; v.typ = t; v.mr = mr; v.mc = mc;
        return v;
    endfunction

    initial begin
        logic [39:0] br, bc, r15, r0, r14, c0, c20;
        // requester i coordinates: 0:(3,4) 1:(5,6) 2:(1023,5) 3:(14,18)
        br  = {10'd14, 10'd1023, 10'd5, 10'd3};
        bc  = {10'd18, 10'd5,    10'd6, 10'd4};
        r15 = {br[39:10], 10'd15};
        c0  = {bc[39:10], 10'd0};
        r0  = {br[39:10], 10'd0};
        c20 = {bc[39:10], 10'd20};
        r14 = {br[39:10], 10'd14};

        vecs[0]  = mk(4'b0001, br, bc, 4'b0001, 4'b0000, 3'd0, 10'd3, 10'd4);
        vecs[1]  = mk(4'b0000, br, bc, 4'b0000, 4'b0001, 3'd0, 10'd3, 10'd4);
        vecs[2]  = mk(4'b0000, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd3, 10'd4);
        vecs[3]  = mk(4'b1111, br, bc, 4'b0010, 4'b0000, 3'd0, 10'd5, 10'd6);
        vecs[4]  = mk(4'b1111, br, bc, 4'b0000, 4'b0010, 3'd4, 10'd5, 10'd6);
        vecs[5]  = mk(4'b1111, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd5, 10'd6);
        vecs[6]  = mk(4'b1111, br, bc, 4'b0100, 4'b0000, 3'd0, 10'd1023, 10'd5);
        vecs[7]  = mk(4'b1111, br, bc, 4'b0000, 4'b0100, 3'd2, 10'd1023, 10'd5);
        vecs[8]  = mk(4'b1111, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd1023, 10'd5);
        vecs[9]  = mk(4'b1111, br, bc, 4'b1000, 4'b0000, 3'd0, 10'd14, 10'd18);
        vecs[10] = mk(4'b1111, br, bc, 4'b0000, 4'b1000, 3'd1, 10'd14, 10'd18);
        vecs[11] = mk(4'b1111, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd14, 10'd18);
        vecs[12] = mk(4'b1111, br, bc, 4'b0001, 4'b0000, 3'd0, 10'd3, 10'd4);
        vecs[13] = mk(4'b0000, br, bc, 4'b0000, 4'b0001, 3'd0, 10'd3, 10'd4);
        vecs[14] = mk(4'b0000, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd3, 10'd4);
        // requester 0 raises req while 1 is busy and drops it before IDLE
        vecs[15] = mk(4'b0010, br, bc, 4'b0010, 4'b0000, 3'd0, 10'd5, 10'd6);
        vecs[16] = mk(4'b0001, br, bc, 4'b0000, 4'b0010, 3'd4, 10'd5, 10'd6);
        vecs[17] = mk(4'b0001, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd5, 10'd6);
        vecs[18] = mk(4'b0000, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd5, 10'd6);
        vecs[19] = mk(4'b0000, br, bc, 4'b0000, 4'b0000, 3'd0, 10'd5, 10'd6);
        // bounds edges: row 15 and column 20 are walls, (14,0) is inside
        vecs[20] = mk(4'b0001, r15, c0, 4'b0001, 4'b0000, 3'd0, 10'd15, 10'd0);
        vecs[21] = mk(4'b0000, r15, c0, 4'b0000, 4'b0001, 3'd2, 10'd15, 10'd0);
        vecs[22] = mk(4'b0000, r15, c0, 4'b0000, 4'b0000, 3'd0, 10'd15, 10'd0);
        vecs[23] = mk(4'b0001, r0, c20, 4'b0001, 4'b0000, 3'd0, 10'd0, 10'd20);
        vecs[24] = mk(4'b0000, r0, c20, 4'b0000, 4'b0001, 3'd2, 10'd0, 10'd20);
        vecs[25] = mk(4'b0000, r0, c20, 4'b0000, 4'b0000, 3'd0, 10'd0, 10'd20);
        vecs[26] = mk(4'b0001, r14, c0, 4'b0001, 4'b0000, 3'd0, 10'd14, 10'd0);
        vecs[27] = mk(4'b0000, r14, c0, 4'b0000, 4'b0001, 3'd7, 10'd14, 10'd0);
        vecs[28] = mk(4'b0000, r14, c0, 4'b0000, 4'b0000, 3'd0, 10'd14, 10'd0);

        rst = 1'b1;
        req_a = '0; req_r_a = br; req_c_a = bc;
        req_b = '0; req_r_b = br; req_c_b = bc;
        cyc();
        cyc();
        chk("reset_gnt", 32'(gnt_a), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("reset_rsp_type", 32'(rsp_type_a), 32'd0);
        chk("reset_map_r", 32'(map_r_a), 32'd0);
        chk("reset_map_c", 32'(map_c_a), 32'd0);
        chk("reset_gnt_b", 32'(gnt_b), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            req_a = vecs[i].req; req_r_a = vecs[i].rr; req_c_a = vecs[i].cc;
            cyc();
            chk($sformatf("v%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid_a), 32'(vecs[i].rv));
            if (vecs[i].rv != 4'b0000)
                chk($sformatf("v%0d_rsp_type", i), 32'(rsp_type_a), 32'(vecs[i].typ));
            chk($sformatf("v%0d_map_r", i), 32'(map_r_a), 32'(vecs[i].mr));
            chk($sformatf("v%0d_map_c", i), 32'(map_c_a), 32'(vecs[i].mc));
        end

        // MAP_LAT=3: coordinates change right after the grant, response uses (2,3)
        req_b = 4'b0100;
        req_r_b = {10'd0, 10'd2, 10'd0, 10'd0};
        req_c_b = {10'd0, 10'd3, 10'd0, 10'd0};
        cyc();
        chk("lat3_gnt", 32'(gnt_b), 32'b0100);
        req_b = 4'b0000;
        req_r_b = {4{10'd9}};
        req_c_b = {4{10'd9}};
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk($sformatf("lat3_wait%0d_gnt", k), 32'(gnt_b), 32'd0);
            chk($sformatf("lat3_wait%0d_rsp_valid", k), 32'(rsp_valid_b), 32'd0);
            chk($sformatf("lat3_wait%0d_map_r", k), 32'(map_r_b), 32'd2);
            chk($sformatf("lat3_wait%0d_map_c", k), 32'(map_c_b), 32'd3);
        end
        cyc();
        chk("lat3_rsp_valid", 32'(rsp_valid_b), 32'b0100);
        chk("lat3_rsp_type", 32'(rsp_type_b), 32'd6);
        cyc();
        chk("lat3_rsp_clear", 32'(rsp_valid_b), 32'd0);

        // Reset while requester 2 is in WAIT, then rr_ptr must restart at 0
        req_a = 4'b0100; req_r_a = br; req_c_a = bc;
        cyc();
        chk("rst_pre_gnt", 32'(gnt_a), 32'b0100);
        rst = 1'b1; req_a = 4'b0000;
        cyc();
        chk("rst_mid_gnt", 32'(gnt_a), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid_a), 32'd0);
        rst = 1'b0;
        cyc();
        chk("rst_after_rsp_valid", 32'(rsp_valid_a), 32'd0);
        cyc();
        chk("rst_after2_rsp_valid", 32'(rsp_valid_a), 32'd0);
        req_a = 4'b1001;
        cyc();
        chk("rst_rr_restart_gnt", 32'(gnt_a), 32'b0001);
        req_a = 4'b1000;
        cyc();
        chk("rst_rr_rsp_valid", 32'(rsp_valid_a), 32'b0001);
        cyc();
        cyc();
        chk("rst_rr_next_gnt", 32'(gnt_a), 32'b1000);
        req_a = 4'b0000;
        cyc();
        chk("rst_rr_next_rsp", 32'(rsp_valid_a), 32'b1000);
        chk("rst_rr_next_type", 32'(rsp_type_a), 32'd1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
